// File: rtl/fabric_pkg.sv
// Shared types and constants for the fabric address router and its tracking FIFO.
package fabric_pkg;

  localparam logic [31:0] FABRIC_ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // Index widths of at least one bit, so that a single-port build still
  // has a legal vector.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  // Locally generated response. The error responder's payload is built from
  // this and then sized to the router's DATA_W.
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } fabric_rsp_t;

endpackage

// File: rtl/fabric_txn_fifo.sv
// In-order tracker of issued requests: each entry is {slave idx, decode err}.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module fabric_txn_fifo
  import fabric_pkg::*;
#(
  parameter int W     = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int               PTR_W = clog2_min1(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fabric_addr_router.sv
// One master to N slaves: base/mask decode, single pipe register, in-order
// response return via a tracking FIFO, and an internal decode-error responder.
module fabric_addr_router
  import fabric_pkg::*;
#(
  parameter int                  N             = 2,
  parameter int                  ADDR_W        = 32,
  parameter int                  DATA_W        = 32,
  parameter int                  SLV_W         = (N <= 1) ? 1 : $clog2(N),
  parameter bit                  HAS_DEFAULT   = 1'b1,
  parameter int                  DEFAULT_SLAVE = 0,
  parameter logic [N*ADDR_W-1:0] SLAVE_BASE    = '0,
  parameter logic [N*ADDR_W-1:0] SLAVE_MASK    = '0,
  parameter int                  MAX_OUTST     = 4,
  parameter logic [31:0]         ERR_DATA      = FABRIC_ERR_DATA_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N-1:0]                     win_en,
  input  logic                             m_req_valid,
  output logic                             m_req_ready,
  input  logic [ADDR_W-1:0]                m_req_addr,
  input  logic                             m_req_write,
  input  logic [DATA_W-1:0]                m_req_wdata,
  output logic [N-1:0]                     s_req_valid,
  input  logic [N-1:0]                     s_req_ready,
  output logic [ADDR_W-1:0]                s_req_addr,
  output logic                             s_req_write,
  output logic [DATA_W-1:0]                s_req_wdata,
  input  logic [N-1:0]                     s_rsp_valid,
  output logic [N-1:0]                     s_rsp_ready,
  input  logic [N*DATA_W-1:0]              s_rsp_rdata,
  input  logic [N-1:0]                     s_rsp_err,
  output logic                             m_rsp_valid,
  input  logic                             m_rsp_ready,
  output logic [DATA_W-1:0]                m_rsp_rdata,
  output logic                             m_rsp_err,
  output logic [$clog2(MAX_OUTST+1)-1:0]   outst_count,
  output logic [15:0]                      decode_err_cnt
);

  localparam int          CNT_W   = $clog2(MAX_OUTST + 1);
  localparam fabric_rsp_t ERR_RSP = '{rdata: ERR_DATA, err: 1'b1};

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [SLV_W-1:0]  idx;
    logic              err;
  } pipe_t;

  pipe_t             dec_req, pipe_q;
  logic              pipe_valid, pipe_leave, accept, room;
  logic              dec_hit;
  logic [SLV_W-1:0]  dec_idx;
  logic [SLV_W-1:0]  head_idx;
  logic              head_err;
  logic              fifo_full, fifo_empty, fifo_pop;

  // Decode: walk from the top so the lowest enabled matching window wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (win_en[i] &&
          ((m_req_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W])) begin
        dec_hit = 1'b1;
        dec_idx = SLV_W'(i);
      end
    end
    dec_req       = '0;
    dec_req.addr  = m_req_addr;
    dec_req.write = m_req_write;
    dec_req.wdata = m_req_wdata;
    if (dec_hit) begin
      dec_req.idx = dec_idx;
    end else if (HAS_DEFAULT) begin
      dec_req.idx = SLV_W'(DEFAULT_SLAVE);
    end else begin
      dec_req.err = 1'b1;
    end
  end

  // A pop this cycle frees the slot the leaving entry needs.
  assign room        = !fifo_full || fifo_pop;
  assign pipe_leave  = pipe_valid && room && (pipe_q.err || s_req_ready[pipe_q.idx]);
  assign m_req_ready = !pipe_valid || pipe_leave;
  assign accept      = m_req_valid && m_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= 1'b0;
      pipe_q     <= '0;
    end else begin
      if (accept) begin
        pipe_valid <= 1'b1;
        pipe_q     <= dec_req;
      end else if (pipe_leave) begin
        pipe_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    s_req_valid = '0;
    if (pipe_valid && room && !pipe_q.err) s_req_valid[pipe_q.idx] = 1'b1;
  end

  assign s_req_addr  = pipe_q.addr;
  assign s_req_write = pipe_q.write;
  assign s_req_wdata = pipe_q.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      decode_err_cnt <= '0;
    end else if (pipe_leave && pipe_q.err && (decode_err_cnt != 16'hFFFF)) begin
      decode_err_cnt <= decode_err_cnt + 1'b1;
    end
  end

  fabric_txn_fifo #(
    .W     (SLV_W + 1),
    .DEPTH (MAX_OUTST),
    .CNT_W (CNT_W)
  ) u_txn_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_leave),
    .push_data ({pipe_q.idx, pipe_q.err}),
    .pop       (fifo_pop),
    .head      ({head_idx, head_err}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outst_count)
  );

  // Response path is driven only by the FIFO head, which enforces request order.
  always_comb begin
    m_rsp_valid = 1'b0;
    m_rsp_rdata = '0;
    m_rsp_err   = 1'b0;
    s_rsp_ready = '0;
    if (!fifo_empty) begin
      if (head_err) begin
        m_rsp_valid = 1'b1;
        m_rsp_rdata = DATA_W'(ERR_RSP.rdata);
        m_rsp_err   = ERR_RSP.err;
      end else begin
        m_rsp_valid           = s_rsp_valid[head_idx];
        m_rsp_rdata           = s_rsp_rdata[head_idx*DATA_W +: DATA_W];
        m_rsp_err             = s_rsp_err[head_idx];
        s_rsp_ready[head_idx] = m_rsp_ready;
      end
    end
  end

  assign fifo_pop = m_rsp_valid && m_rsp_ready;

endmodule

// File: tb/tb_fabric_addr_router.sv
// Directed scoreboard bench: stimulus queues expected responses, a monitor
// pops and compares on every master response handshake.
module tb_fabric_addr_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT: no default slave
  logic [1:0]  win_en = 2'b11;
  logic        m_req_valid = 1'b0, m_req_ready;
  logic [31:0] m_req_addr = '0;
  logic        m_req_write = 1'b0;
  logic [31:0] m_req_wdata = '0;
  logic [1:0]  s_req_valid;
  logic [1:0]  s_req_ready = 2'b11;
  logic [31:0] s_req_addr;
  logic        s_req_write;
  logic [31:0] s_req_wdata;
  logic [1:0]  s_rsp_valid, s_rsp_ready;
  logic [63:0] s_rsp_rdata;
  logic [1:0]  s_rsp_err = 2'b00;
  logic        m_rsp_valid, m_rsp_err;
  logic        m_rsp_ready = 1'b1;
  logic [31:0] m_rsp_rdata;
  logic [1:0]  outst_count;
  logic [15:0] decode_err_cnt;
  logic [1:0]  rsp_en = 2'b11;

  // second DUT: default slave enabled
  logic [1:0]  d_win_en = 2'b01;
  logic        d_m_req_valid = 1'b0, d_m_req_ready;
  logic [31:0] d_m_req_addr = '0;
  logic [1:0]  d_s_req_valid;
  logic [31:0] d_s_req_addr;
  logic        d_s_req_write;
  logic [31:0] d_s_req_wdata;
  logic [1:0]  d_s_rsp_valid = 2'b00, d_s_rsp_ready;
  logic [63:0] d_s_rsp_rdata = '0;
  logic        d_m_rsp_valid, d_m_rsp_err;
  logic [31:0] d_m_rsp_rdata;
  logic [1:0]  d_outst_count;
  logic [15:0] d_decode_err_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;

  fabric_addr_router #(
    .N(2), .ADDR_W(32), .DATA_W(32), .HAS_DEFAULT(1'b0), .DEFAULT_SLAVE(0),
    .SLAVE_BASE({32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hF000_0000, 32'hF000_0000}),
    .MAX_OUTST(2), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst), .win_en(win_en),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_write(m_req_write), .m_req_wdata(m_req_wdata),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_write(s_req_write), .s_req_wdata(s_req_wdata),
    .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
    .s_rsp_err(s_rsp_err),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_rdata(m_rsp_rdata),
    .m_rsp_err(m_rsp_err), .outst_count(outst_count), .decode_err_cnt(decode_err_cnt)
  );

  fabric_addr_router #(
    .N(2), .ADDR_W(32), .DATA_W(32), .HAS_DEFAULT(1'b1), .DEFAULT_SLAVE(0),
    .SLAVE_BASE({32'h1000_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hF000_0000, 32'hF000_0000}),
    .MAX_OUTST(2), .ERR_DATA(32'hDEAD_BEEF)
  ) dut_d (
    .clk(clk), .rst(rst), .win_en(d_win_en),
    .m_req_valid(d_m_req_valid), .m_req_ready(d_m_req_ready), .m_req_addr(d_m_req_addr),
    .m_req_write(1'b0), .m_req_wdata(32'h0),
    .s_req_valid(d_s_req_valid), .s_req_ready(2'b11), .s_req_addr(d_s_req_addr),
    .s_req_write(d_s_req_write), .s_req_wdata(d_s_req_wdata),
    .s_rsp_valid(d_s_rsp_valid), .s_rsp_ready(d_s_rsp_ready), .s_rsp_rdata(d_s_rsp_rdata),
    .s_rsp_err(2'b00),
    .m_rsp_valid(d_m_rsp_valid), .m_rsp_ready(1'b1), .m_rsp_rdata(d_m_rsp_rdata),
    .m_rsp_err(d_m_rsp_err), .outst_count(d_outst_count), .decode_err_cnt(d_decode_err_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Slave models: accept per s_req_ready, answer in order with programmed data
  // while rsp_en is set.
  for (genvar g = 0; g < 2; g++) begin : slv
    logic [31:0] prog[$];
    int          pend;
    logic [31:0] rdat;
    logic        rq, rs;
    assign s_rsp_valid[g]          = rsp_en[g] && (pend > 0);
    assign s_rsp_rdata[g*32 +: 32] = rdat;
    initial begin
      pend = 0;
      rdat = '0;
      forever begin
        @(negedge clk);
        rq = s_req_valid[g] && s_req_ready[g];
        rs = s_rsp_valid[g] && s_rsp_ready[g];
        @(posedge clk);
        #1;
        if (rst) begin
          prog.delete();
          pend = 0;
        end else begin
          if (rs) begin
            void'(prog.pop_front());
            pend--;
          end
          if (rq) pend++;
        end
        rdat = (prog.size() != 0) ? prog[0] : 32'h0;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && m_rsp_valid && m_rsp_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp: got rdata %0h, want no response", m_rsp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", m_rsp_rdata, mon_e[31:0]);
        chk("rsp_err", {31'h0, m_rsp_err}, {31'h0, mon_e[32]});
      end
    end
  end

  task automatic send(input logic [31:0] addr);
    int  n = 0;
    logic acc = 1'b0;
    m_req_valid = 1'b1;
    m_req_addr  = addr;
    m_req_write = 1'b0;
    m_req_wdata = addr ^ 32'h5A5A_5A5A;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = m_req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    m_req_valid = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: addr %0h not accepted, want accept", addr);
    end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d responses outstanding, want 0", nm, exp_q.size());
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_outst", {30'h0, outst_count}, 32'h0);
    chk("rst_s_req_valid", {30'h0, s_req_valid}, 32'h0);
    chk("rst_m_rsp_valid", {31'h0, m_rsp_valid}, 32'h0);
    chk("rst_s_rsp_ready", {30'h0, s_rsp_ready}, 32'h0);
    chk("rst_err_cnt", {16'h0, decode_err_cnt}, 32'h0);
    rst = 1'b0;
    cyc();
    chk("rst_m_req_ready", {31'h0, m_req_ready}, 32'h1);

    // 1: mapped read to slave1
    slv[1].prog.push_back(32'h1234);
    exp_q.push_back({1'b0, 32'h1234});
    send(32'h1000_0040);
    chk("t1_s_req_valid", {30'h0, s_req_valid}, 32'h2);
    chk("t1_s_req_addr", s_req_addr, 32'h1000_0040);
    drain("t1_drain");
    chk("t1_err_cnt", {16'h0, decode_err_cnt}, 32'h0);

    // 2: unmapped read goes to the error responder
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    send(32'h2000_0000);
    chk("t2_no_s_req", {30'h0, s_req_valid}, 32'h0);
    chk("t2_rsp_not_yet", {31'h0, m_rsp_valid}, 32'h0);
    cyc();
    chk("t2_rsp_t2", {31'h0, m_rsp_valid}, 32'h1);
    drain("t2_drain");
    chk("t2_err_cnt", {16'h0, decode_err_cnt}, 32'h1);

    // 3: slave1 answers first but must wait behind slave0
    rsp_en = 2'b00;
    slv[0].prog.push_back(32'hA0A0);
    slv[1].prog.push_back(32'hB1B1);
    exp_q.push_back({1'b0, 32'hA0A0});
    exp_q.push_back({1'b0, 32'hB1B1});
    send(32'h0000_0100);
    send(32'h1000_0200);
    rsp_en = 2'b10;
    repeat (3) cyc();
    chk("t3_s_rsp_ready1", {31'h0, s_rsp_ready[1]}, 32'h0);
    chk("t3_m_rsp_held", {31'h0, m_rsp_valid}, 32'h0);
    rsp_en = 2'b11;
    drain("t3_drain");

    // 4: tracking FIFO full, third request held in the pipe
    rsp_en = 2'b00;
    slv[0].prog.push_back(32'hC0);
    slv[0].prog.push_back(32'hC1);
    slv[0].prog.push_back(32'hC2);
    exp_q.push_back({1'b0, 32'hC0});
    exp_q.push_back({1'b0, 32'hC1});
    exp_q.push_back({1'b0, 32'hC2});
    send(32'h0000_0010);
    send(32'h0000_0020);
    send(32'h0000_0030);
    chk("t4_outst_full", {30'h0, outst_count}, 32'h2);
    chk("t4_req_ready_low", {31'h0, m_req_ready}, 32'h0);
    chk("t4_s_req_blocked", {30'h0, s_req_valid}, 32'h0);
    rsp_en = 2'b01;
    @(negedge clk);
    chk("t4_pop_rsp", {31'h0, m_rsp_valid}, 32'h1);
    chk("t4_pop_issue", {30'h0, s_req_valid}, 32'h1);
    chk("t4_pop_ready", {31'h0, m_req_ready}, 32'h1);
    cyc();
    chk("t4_outst_same", {30'h0, outst_count}, 32'h2);
    drain("t4_drain");
    rsp_en = 2'b11;

    // 5: disabled window becomes a decode error
    win_en = 2'b01;
    exp_q.push_back({1'b1, 32'hDEAD_BEEF});
    send(32'h1000_0000);
    chk("t5_no_s_req", {30'h0, s_req_valid}, 32'h0);
    drain("t5_drain");
    chk("t5_err_cnt", {16'h0, decode_err_cnt}, 32'h2);
    win_en = 2'b11;

    // 5b: same request with a default slave routes to slave0
    d_m_req_valid = 1'b1;
    d_m_req_addr  = 32'h1000_0000;
    @(negedge clk);
    chk("t5d_req_ready", {31'h0, d_m_req_ready}, 32'h1);
    cyc();
    d_m_req_valid = 1'b0;
    chk("t5d_route", {30'h0, d_s_req_valid}, 32'h1);
    cyc();
    d_s_rsp_valid = 2'b01;
    d_s_rsp_rdata = {32'h0, 32'h5555};
    @(negedge clk);
    chk("t5d_rsp_valid", {31'h0, d_m_rsp_valid}, 32'h1);
    chk("t5d_rsp_rdata", d_m_rsp_rdata, 32'h5555);
    chk("t5d_rsp_err", {31'h0, d_m_rsp_err}, 32'h0);
    cyc();
    d_s_rsp_valid = 2'b00;
    chk("t5d_outst", {30'h0, d_outst_count}, 32'h0);
    chk("t5d_err_cnt", {16'h0, d_decode_err_cnt}, 32'h0);

    // 6: asynchronous reset with FIFO full and a pipe entry held
    rsp_en = 2'b00;
    slv[0].prog.push_back(32'hD0);
    slv[0].prog.push_back(32'hD1);
    slv[0].prog.push_back(32'hD2);
    send(32'h0000_0040);
    send(32'h0000_0050);
    send(32'h0000_0060);
    chk("t6_outst_full", {30'h0, outst_count}, 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_outst", {30'h0, outst_count}, 32'h0);
    chk("t6_rst_s_req", {30'h0, s_req_valid}, 32'h0);
    chk("t6_rst_m_rsp", {31'h0, m_rsp_valid}, 32'h0);
    chk("t6_rst_s_rsp_ready", {30'h0, s_rsp_ready}, 32'h0);
    chk("t6_rst_err_cnt", {16'h0, decode_err_cnt}, 32'h0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("t6_req_ready", {31'h0, m_req_ready}, 32'h1);
    rsp_en = 2'b11;
    slv[1].prog.push_back(32'h7777);
    exp_q.push_back({1'b0, 32'h7777});
    send(32'h1000_0008);
    chk("t6_s_req_valid", {30'h0, s_req_valid}, 32'h2);
    drain("t6_drain");

    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fabric_addr_router.md
Name: fabric_addr_router

Overview:
- Registered, handshaked request router for one fabric master port fanned out to N slave ports.
- Decodes each request against a base/mask window table, gated by runtime window enables, with first-match priority.
- Issues the request to the selected slave and tracks outstanding targets in order, so responses return to the master in request order.
- Unmapped requests are absorbed by an internal error responder; no slave sees them. Sits between a CPU/DMA master and the fabric slave ports.

Parameters:
- N, 2, number of slave ports (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SLV_W, (N<=1)?1:$clog2(N), slave index width
- HAS_DEFAULT, 1, unmapped requests go to DEFAULT_SLAVE instead of the error responder
- DEFAULT_SLAVE, 0, default target index
- SLAVE_BASE, '0, N*ADDR_W packed window bases; window i at [i*ADDR_W +: ADDR_W]
- SLAVE_MASK, '0, N*ADDR_W packed window masks, same packing
- MAX_OUTST, 4, maximum outstanding requests (1..16); tracking FIFO depth
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on a decode error (zero-extended or truncated to DATA_W)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- win_en  in  N  per-window enable; sampled at request accept
- m_req_valid / m_req_ready  in / out  1 / 1  master request handshake
- m_req_addr  in  ADDR_W  request address
- m_req_write  in  1  1 = write
- m_req_wdata  in  DATA_W  write data
- s_req_valid / s_req_ready  out / in  N / N  per-slave request handshake
- s_req_addr / s_req_write / s_req_wdata  out  ADDR_W / 1 / DATA_W  broadcast request payload from the pipe register
- s_rsp_valid / s_rsp_ready  in / out  N / N  per-slave response handshake
- s_rsp_rdata  in  N*DATA_W  packed response data
- s_rsp_err  in  N  slave error flags
- m_rsp_valid / m_rsp_ready  out / in  1 / 1  master response handshake
- m_rsp_rdata  out  DATA_W  response data
- m_rsp_err  out  1  response error flag
- outst_count  out  $clog2(MAX_OUTST+1)  requests issued but not yet responded
- decode_err_cnt  out  16  saturating count of unmapped requests

Behaviour:
- Reset: all pipe, FIFO and counter state cleared. s_req_valid=0, m_rsp_valid=0, s_rsp_ready=0, outst_count=0, decode_err_cnt=0. m_req_ready=1 once reset is released.
- Decode is combinational on m_req_addr.
  - Window i hits when win_en[i] && ((addr & MASK_i) == BASE_i); the lowest i wins.
  - On a miss: with HAS_DEFAULT, target = DEFAULT_SLAVE; otherwise error = 1.
- Pipe register (one entry): holds {addr, write, wdata, idx, err}.
  - m_req_ready = !pipe_valid || pipe_leave.
  - Accept loads the pipe at the clock edge.
- Issue: pipe_leave requires room in the FIFO, defined as count < MAX_OUTST or a FIFO pop in the same cycle.
  - Non-error entry: s_req_valid[idx] = pipe_valid && room; leaves on s_req_ready[idx].
  - Error entry: leaves the first cycle room is true, with no slave request; decode_err_cnt increments, saturating at 16'hFFFF.
  - In both cases {idx, err} is pushed to the tracking FIFO on leave.
- Latency:
  - Accept at edge t gives s_req_valid from cycle t+1.
  - An error response is valid from t+2 at the earliest, if the FIFO was empty.
  - Back-to-back accepts sustain 1 request/cycle while slaves are ready and the FIFO has room.
- Responses come only from the FIFO head.
  - Head non-error: m_rsp_valid = s_rsp_valid[h], rdata/err muxed from slave h, s_rsp_ready[h] = m_rsp_ready. All other s_rsp_ready = 0.
  - Head error: m_rsp_valid = 1, m_rsp_rdata = ERR_DATA, m_rsp_err = 1.
  - FIFO pops on the m_rsp handshake.
  - FIFO empty: m_rsp_valid = 0 and all s_rsp_ready = 0.
- outst_count = FIFO occupancy. Push and pop in the same cycle leaves it unchanged, including when full.
- Stability: once s_req_valid or m_rsp_valid is raised for a locally generated response, payload is held until the handshake completes.
- win_en changes affect only requests not yet accepted.
- A reset mid-transaction drops all in-flight state; slaves must be reset together with this block.

Decomposition:
- fabric_pkg holds:
  - localparam function clog2_min1
  - typedef fabric_rsp_t {rdata, err}
  - constant FABRIC_ERR_DATA_DEFAULT
- Sub-module fabric_txn_fifo: synchronous FIFO of {idx, err}, depth MAX_OUTST, with push/pop/full/empty/count.
- Decode stays inline.

Test Plan:
Config for all scenarios: N=2, SLAVE_BASE={0x1000_0000, 0x0000_0000}, SLAVE_MASK both 0xF000_0000, HAS_DEFAULT=0, MAX_OUTST=2, win_en=2'b11.
1. Read 0x1000_0040; slave1 ready; slave1 responds rdata=0x1234, err=0 -> s_req_valid=2'b10 at t+1; m_rsp rdata=0x1234, err=0; decode_err_cnt=0.
2. Read 0x2000_0000 -> no s_req_valid; m_rsp_valid at t+2 with rdata=0xDEAD_BEEF, err=1; decode_err_cnt=1.
3. Issue reads to slave0 then slave1; slave1 responds first -> s_rsp_ready[1] held 0 until slave0's response is returned; master sees slave0's data, then slave1's.
4. Three back-to-back reads with responses stalled -> outst_count=2; m_req_ready drops after the third accept. The first m_rsp pop releases the third request the same cycle; outst_count stays 2.
5. win_en=2'b01, read 0x1000_0000 -> decode error, err=1. With HAS_DEFAULT=1, DEFAULT_SLAVE=0 -> routed to slave0.
6. Assert rst with outst_count=2 and a pipe entry held -> all outputs return to reset values asynchronously; the next request decodes normally.
